// File: rtl/mma_pkg.sv
// Shared definitions for the MMA command controller.
//   - Host command and response byte codes.
//   - Controller state encoding (also driven out as the debug state code).
//   - be_byte: picks byte idx (0 = MSB) out of a big-endian 32-bit word.
package mma_pkg;

  localparam logic [7:0] CMD_RX_A  = 8'h01;
  localparam logic [7:0] CMD_RX_B  = 8'h02;
  localparam logic [7:0] CMD_MUL   = 8'h03;
  localparam logic [7:0] CMD_TX_R  = 8'h04;

  localparam logic [7:0] RSP_DONE  = 8'h05;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_ERR   = 8'hAA;

  typedef enum logic [7:0] {
    ST_IDLE      = 8'h00,
    ST_RX_HDR    = 8'h01,
    ST_RX_DATA   = 8'h02,
    ST_SEND_ACK  = 8'h03,
    ST_CHECK     = 8'h04,
    ST_MUL_WAIT  = 8'h05,
    ST_SEND_DONE = 8'h06,
    ST_TX_HDR    = 8'h07,
    ST_TX_FETCH  = 8'h08,
    ST_TX_BYTE   = 8'h09,
    ST_ERR       = 8'h0A,
    ST_FLUSH     = 8'h0B
  } state_t;

  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    be_byte = w[31:24];
      2'd1:    be_byte = w[23:16];
      2'd2:    be_byte = w[15:8];
      default: be_byte = w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/mma_byte_tx.sv
// Single-byte transmit handshake towards the UART transmitter.
//   clk, reset : system clock, synchronous active-high reset
//   send, data : request to send `data`; held by the caller until `done`
//   tx_busy    : UART transmitter busy
//   tx_data    : byte presented to the UART (latched when the request is taken)
//   tx_begin   : one-cycle transmit request
//   done       : one-cycle pulse once the UART has gone idle after the byte
module mma_byte_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_begin,
  output logic       done
);

  typedef enum logic [1:0] {
    BT_IDLE,
    BT_PULSE,
    BT_GUARD,
    BT_WAIT
  } bt_state_t;

  bt_state_t st_q, st_d;
  logic [7:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= BT_IDLE;
      data_q <= 8'h00;
    end else begin
      st_q <= st_d;
      if (st_q == BT_IDLE && send && !tx_busy) data_q <= data;
    end
  end

  // BT_GUARD covers the cycle in which the UART has not yet raised busy
  // in response to the pulse, so busy is not looked at there.
  always_comb begin
    st_d = st_q;
    done = 1'b0;
    case (st_q)
      BT_IDLE:  if (send && !tx_busy) st_d = BT_PULSE;
      BT_PULSE: st_d = BT_GUARD;
      BT_GUARD: st_d = BT_WAIT;
      BT_WAIT: begin
        if (!tx_busy) begin
          done = 1'b1;
          st_d = BT_IDLE;
        end
      end
      default:  st_d = BT_IDLE;
    endcase
  end

  assign tx_begin = (st_q == BT_PULSE);
  assign tx_data  = data_q;

endmodule

// File: rtl/mma_cmd_ctrl.sv
// Command sequencer between the UART byte stream and the matrix-multiply
// datapath. Parses load/multiply/return commands, writes big-endian operand
// words into the A/B memories, launches the engine and streams the result
// back with ACK/DONE/ERR responses.
//   rx_data/rx_ready/rx_error  : received byte stream
//   tx_data/tx_begin/tx_busy   : transmit byte stream
//   mem_we/mem_sel/mem_addr/mem_wdata : operand memory write port (sel 0=A, 1=B)
//   a_rows/a_cols/b_cols       : latched dimensions for the engine
//   mul_start/mul_done         : engine launch / completion
//   res_addr/res_rdata         : result memory read (data one cycle after addr)
//   state                      : current state code
module mma_cmd_ctrl
  import mma_pkg::*;
#(
  parameter int MAX_DIM        = 8,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  output logic [7:0]        tx_data,
  output logic              tx_begin,
  input  logic              tx_busy,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        a_rows,
  output logic [7:0]        a_cols,
  output logic [7:0]        b_cols,
  output logic              mul_start,
  input  logic              mul_done,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [31:0]       res_rdata,
  output logic [7:0]        state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  state_t             state_q, state_d;
  logic [23:0]        word_sr;
  logic [1:0]         byte_cnt;
  logic               hdr_idx;
  logic               tgt_b;
  logic               fetch_ph;
  logic [7:0]         b_rows;
  logic               a_valid, b_valid, res_valid;
  logic [CNT_W-1:0]   elem_cnt;
  logic [31:0]        res_word;
  logic [TMO_W-1:0]   tmo_cnt;

  logic [31:0]        rx_word;
  logic               word_last, dim_ok, tmo_hit;
  logic [7:0]         cur_rows, cur_cols;
  logic [15:0]        load_total, res_total;
  logic [CNT_W-1:0]   elem_next;
  logic               load_last, res_last;

  logic               start_load, tx_hdr_go, shift, store_dim, wr_elem;
  logic               set_ld_valid, set_res_valid, tx_adv, hdr_to_cols;
  logic               fetch_go, fetch_latch;
  logic [CNT_W-1:0]   fetch_idx;
  logic               tx_send, tx_done;
  logic [7:0]         tx_byte;

  assign rx_word    = {word_sr, rx_data};
  assign word_last  = (byte_cnt == 2'd3);
  assign dim_ok     = (rx_word != 32'd0) && (rx_word <= 32'(MAX_DIM));
  assign cur_rows   = tgt_b ? b_rows : a_rows;
  assign cur_cols   = tgt_b ? b_cols : a_cols;
  assign load_total = 16'(cur_rows) * 16'(cur_cols);
  assign res_total  = 16'(a_rows) * 16'(b_cols);
  assign elem_next  = elem_cnt + CNT_W'(1);
  assign load_last  = (16'(elem_next) == load_total);
  assign res_last   = (16'(elem_next) == res_total);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) && !rx_ready;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mul_start     = 1'b0;
    tx_send       = 1'b0;
    tx_byte       = 8'h00;
    start_load    = 1'b0;
    tx_hdr_go     = 1'b0;
    shift         = 1'b0;
    store_dim     = 1'b0;
    wr_elem       = 1'b0;
    set_ld_valid  = 1'b0;
    set_res_valid = 1'b0;
    tx_adv        = 1'b0;
    hdr_to_cols   = 1'b0;
    fetch_go      = 1'b0;
    fetch_idx     = '0;
    fetch_latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_error) begin
          state_d = ST_ERR;
        end else if (rx_ready) begin
          case (rx_data)
            CMD_RX_A, CMD_RX_B: begin
              start_load = 1'b1;
              state_d    = ST_RX_HDR;
            end
            CMD_MUL: state_d = ST_CHECK;
            CMD_TX_R: begin
              if (res_valid) begin
                tx_hdr_go = 1'b1;
                state_d   = ST_TX_HDR;
              end else begin
                state_d = ST_ERR;
              end
            end
            default: state_d = ST_ERR;
          endcase
        end
      end
      ST_RX_HDR: begin
        if (rx_error) begin
          state_d = ST_ERR;
        end else if (rx_ready) begin
          shift = 1'b1;
          if (word_last) begin
            if (!dim_ok) begin
              state_d = ST_ERR;
            end else begin
              store_dim = 1'b1;
              if (hdr_idx) state_d = ST_RX_DATA;
            end
          end
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_RX_DATA: begin
        if (rx_error) begin
          state_d = ST_ERR;
        end else if (rx_ready) begin
          shift = 1'b1;
          if (word_last) begin
            wr_elem = 1'b1;
            if (load_last) begin
              set_ld_valid = 1'b1;
              state_d      = ST_SEND_ACK;
            end
          end
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_SEND_ACK: begin
        tx_send = 1'b1;
        tx_byte = RSP_ACK;
        if (tx_done) state_d = ST_IDLE;
      end
      ST_CHECK: begin
        if (a_valid && b_valid && (a_cols == b_rows)) begin
          mul_start = 1'b1;
          state_d   = ST_MUL_WAIT;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_MUL_WAIT: begin
        if (mul_done) begin
          set_res_valid = 1'b1;
          state_d       = ST_SEND_DONE;
        end
      end
      ST_SEND_DONE: begin
        tx_send = 1'b1;
        tx_byte = RSP_DONE;
        if (tx_done) state_d = ST_IDLE;
      end
      ST_TX_HDR: begin
        tx_send = 1'b1;
        tx_byte = be_byte({24'h0, hdr_idx ? b_cols : a_rows}, byte_cnt);
        if (tx_done) begin
          tx_adv = 1'b1;
          if (word_last) begin
            if (hdr_idx) begin
              fetch_go = 1'b1;
              state_d  = ST_TX_FETCH;
            end else begin
              hdr_to_cols = 1'b1;
            end
          end
        end
      end
      ST_TX_FETCH: begin
        if (fetch_ph) begin
          fetch_latch = 1'b1;
          state_d     = ST_TX_BYTE;
        end
      end
      ST_TX_BYTE: begin
        tx_send = 1'b1;
        tx_byte = be_byte(res_word, byte_cnt);
        if (tx_done) begin
          tx_adv = 1'b1;
          if (word_last) begin
            if (res_last) begin
              state_d = ST_IDLE;
            end else begin
              fetch_go  = 1'b1;
              fetch_idx = elem_next;
              state_d   = ST_TX_FETCH;
            end
          end
        end
      end
      ST_ERR: begin
        tx_send = 1'b1;
        tx_byte = RSP_ERR;
        if (tx_done) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (tmo_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt  <= 2'd0;
      hdr_idx   <= 1'b0;
      tgt_b     <= 1'b0;
      fetch_ph  <= 1'b0;
      a_rows    <= 8'h00;
      a_cols    <= 8'h00;
      b_rows    <= 8'h00;
      b_cols    <= 8'h00;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      res_valid <= 1'b0;
      elem_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      res_addr  <= '0;
      tmo_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;

      // Idle-gap counter restarts on every byte and on every state change.
      if (rx_ready || (state_d != state_q))        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_W'(TIMEOUT_CYCLES))  tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (start_load) begin
        tgt_b     <= (rx_data == CMD_RX_B);
        hdr_idx   <= 1'b0;
        byte_cnt  <= 2'd0;
        res_valid <= 1'b0;
        if (rx_data == CMD_RX_B) b_valid <= 1'b0;
        else                     a_valid <= 1'b0;
      end
      if (tx_hdr_go) begin
        hdr_idx  <= 1'b0;
        byte_cnt <= 2'd0;
      end
      if (shift || tx_adv) byte_cnt <= byte_cnt + 2'd1;

      if (store_dim) begin
        if (!hdr_idx) begin
          if (tgt_b) b_rows <= rx_word[7:0];
          else       a_rows <= rx_word[7:0];
          hdr_idx <= 1'b1;
        end else begin
          if (tgt_b) b_cols <= rx_word[7:0];
          else       a_cols <= rx_word[7:0];
          elem_cnt <= '0;
        end
      end

      if (wr_elem) begin
        mem_we    <= 1'b1;
        mem_sel   <= tgt_b;
        mem_addr  <= elem_cnt[ADDR_W-1:0];
        mem_wdata <= rx_word;
        elem_cnt  <= elem_next;
      end
      if (set_ld_valid) begin
        if (tgt_b) b_valid <= 1'b1;
        else       a_valid <= 1'b1;
      end
      if (set_res_valid) res_valid <= 1'b1;
      if (hdr_to_cols)   hdr_idx   <= 1'b1;

      // fetch_ph: 0 while res_addr is presented, 1 when res_rdata is valid.
      if (fetch_go) begin
        elem_cnt <= fetch_idx;
        res_addr <= fetch_idx[ADDR_W-1:0];
        fetch_ph <= 1'b0;
      end else if (state_q == ST_TX_FETCH) begin
        fetch_ph <= 1'b1;
      end
      if (fetch_latch) byte_cnt <= 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (shift)       word_sr  <= rx_word[23:0];
    if (fetch_latch) res_word <= res_rdata;
  end

  mma_byte_tx u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .send     (tx_send),
    .data     (tx_byte),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_begin (tx_begin),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_mma_cmd_ctrl.sv
// Scoreboard bench for mma_cmd_ctrl: stimulus pushes expected transmit
// bytes and operand writes into queues, a monitor pops and compares them
// whenever the DUT raises tx_begin or mem_we.
module tb_mma_cmd_ctrl;

  localparam int ADDR_W = 6;
  localparam int TMO    = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rx_error;
  logic [7:0]        tx_data;
  logic              tx_begin;
  logic              tx_busy;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [7:0]        a_rows, a_cols, b_cols;
  logic              mul_start;
  logic              mul_done;
  logic [ADDR_W-1:0] res_addr;
  logic [31:0]       res_rdata;
  logic [7:0]        state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic [7:0]  exp_tx[$];
  wr_t         exp_wr[$];
  logic [31:0] elem_q[$];
  logic [7:0]  mon_b;
  wr_t         mon_w;

  int          busy_cnt   = 0;
  int          mul_starts = 0;
  int          mul_timer  = 0;
  logic        stub_done  = 1'b0;
  logic        inj_done   = 1'b0;
  logic [31:0] res_mem [64];

  mma_cmd_ctrl #(
    .MAX_DIM        (8),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rx_error  (rx_error),
    .tx_data   (tx_data),
    .tx_begin  (tx_begin),
    .tx_busy   (tx_busy),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .a_rows    (a_rows),
    .a_cols    (a_cols),
    .b_cols    (b_cols),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .res_addr  (res_addr),
    .res_rdata (res_rdata),
    .state     (state)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for 6 cycles after each begin pulse.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (reset)             busy_cnt <= 0;
    else if (tx_begin)     busy_cnt <= 6;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Multiply engine stub: done 20 cycles after each start.
  assign mul_done = stub_done | inj_done;
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (mul_start) begin
      mul_starts <= mul_starts + 1;
      mul_timer  <= 20;
    end else if (mul_timer > 0) begin
      mul_timer <= mul_timer - 1;
      if (mul_timer == 1) stub_done <= 1'b1;
    end
  end

  // Result memory stub, one cycle read latency.
  always @(posedge clk) res_rdata <= res_mem[res_addr];

  // Monitor
  always @(negedge clk) begin
    if (!reset && tx_begin) begin
      checks++;
      if (exp_tx.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected actual=%h required=none", tx_data);
      end else begin
        mon_b = exp_tx.pop_front();
        if (tx_data !== mon_b) begin
          failures++;
          $display("FAIL tx_byte actual=%h required=%h", tx_data, mon_b);
        end
      end
      checks++;
      if (tx_busy !== 1'b0) begin
        failures++;
        $display("FAIL tx_begin_while_busy actual=%b required=0", tx_busy);
      end
    end
    if (!reset && mem_we) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected actual=%b/%0d/%h required=none", mem_sel, mem_addr, mem_wdata);
      end else begin
        mon_w = exp_wr.pop_front();
        if (mem_sel !== mon_w.sel || mem_addr !== mon_w.addr || mem_wdata !== mon_w.data) begin
          failures++;
          $display("FAIL mem_write actual=%b/%0d/%h required=%b/%0d/%h",
                   mem_sel, mem_addr, mem_wdata, mon_w.sel, mon_w.addr, mon_w.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31:24]);
      w = w << 8;
    end
  endtask

  task automatic exp_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(w[31:24]);
      w = w << 8;
    end
  endtask

  task automatic load_mat(input logic [7:0] cmd, input logic sel, input int rows, input int cols);
    wr_t w;
    for (int i = 0; i < rows * cols; i++) begin
      w.sel  = sel;
      w.addr = ADDR_W'(i);
      w.data = elem_q[i];
      exp_wr.push_back(w);
    end
    exp_tx.push_back(8'h06);
    send_byte(cmd);
    send_word(32'(rows));
    send_word(32'(cols));
    for (int i = 0; i < rows * cols; i++) send_word(elem_q[i]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(state == 8'h00 && exp_tx.size() == 0 && exp_wr.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout actual=state %h pend_tx %0d pend_wr %0d required=idle",
               name, state, exp_tx.size(), exp_wr.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int m0;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    for (int i = 0; i < 64; i++) res_mem[i] = 32'h0;
    res_mem[0] = 32'h41980000;
    res_mem[1] = 32'h41B00000;
    res_mem[2] = 32'h422C0000;
    res_mem[3] = 32'h42480000;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state",     32'(state),     32'h00);
    check("reset_tx_begin",  32'(tx_begin),  32'h0);
    check("reset_mem_we",    32'(mem_we),    32'h0);
    check("reset_mul_start", 32'(mul_start), 32'h0);

    // Return-result before any multiply
    exp_tx.push_back(8'hAA);
    send_byte(8'h04);
    wait_idle("tx_r_early", 600);

    // Reset in the middle of an A load
    begin
      wr_t w;
      w.sel = 1'b0; w.addr = '0; w.data = 32'h3F800000;
      exp_wr.push_back(w);
    end
    send_byte(8'h01);
    send_word(32'd2);
    send_word(32'd2);
    send_word(32'h3F800000);
    send_byte(8'h40);
    send_byte(8'h00);
    check("mid_load_state", 32'(state), 32'h02);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_state",    32'(state),    32'h00);
    check("midreset_mem_we",   32'(mem_we),   32'h0);
    check("midreset_tx_begin", 32'(tx_begin), 32'h0);
    check("midreset_a_rows",   32'(a_rows),   32'h00);
    reset = 1'b0;
    @(negedge clk);

    // Load A 2x2
    elem_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    load_mat(8'h01, 1'b0, 2, 2);
    wait_idle("load_a", 600);
    check("a_rows_2x2", 32'(a_rows), 32'd2);

    // Load B 2x2
    elem_q = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    load_mat(8'h02, 1'b1, 2, 2);
    wait_idle("load_b", 600);
    check("b_cols_2x2", 32'(b_cols), 32'd2);

    // Multiply
    m0 = mul_starts;
    exp_tx.push_back(8'h05);
    send_byte(8'h03);
    wait_idle("multiply", 600);
    check("mul_start_pulses", 32'(mul_starts - m0), 32'd1);

    // Return result twice
    for (int r = 0; r < 2; r++) begin
      exp_word(32'd2);
      exp_word(32'd2);
      for (int i = 0; i < 4; i++) exp_word(res_mem[i]);
      send_byte(8'h04);
      wait_idle("tx_result", 2000);
    end

    // Stray mul_done in IDLE is ignored
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_mul_done_state", 32'(state), 32'h00);

    // A 2x3 against B 2x2: dimension mismatch
    elem_q = '{32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000};
    load_mat(8'h01, 1'b0, 2, 3);
    wait_idle("load_a_2x3", 800);
    check("a_cols_2x3", 32'(a_cols), 32'd3);
    m0 = mul_starts;
    exp_tx.push_back(8'hAA);
    send_byte(8'h03);
    wait_idle("mul_mismatch", 600);
    check("mismatch_no_start", 32'(mul_starts - m0), 32'd0);

    // Result was invalidated by the new load
    exp_tx.push_back(8'hAA);
    send_byte(8'h04);
    wait_idle("tx_r_invalid", 600);

    // Header rows=9 out of range, extra bytes swallowed by the flush
    exp_tx.push_back(8'hAA);
    send_byte(8'h01);
    send_word(32'd9);
    send_byte(8'h55);
    send_byte(8'h01);
    wait_idle("bad_rows", 800);
    check("bad_rows_a_rows", 32'(a_rows), 32'd2);

    // Stall mid-element past the timeout
    exp_tx.push_back(8'hAA);
    send_byte(8'h02);
    send_word(32'd1);
    send_word(32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    wait_idle("rx_timeout", 800);
    check("timeout_b_cols", 32'(b_cols), 32'd1);

    // Unknown command
    exp_tx.push_back(8'hAA);
    send_byte(8'h07);
    wait_idle("stray_cmd", 600);

    // Framing error inside a load
    exp_tx.push_back(8'hAA);
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge clk);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    wait_idle("rx_error", 600);

    check("final_state", 32'(state), 32'h00);
    check("pending_tx",  32'(exp_tx.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
